// File: rtl/result_conditioning.sv
// ---------------------------------------------------------------------------
// result_conditioning
//
// Output stage of the multiply/divide unit. Captures one raw result from the
// multiply/divide core and selects the word the opCode asks for. It then
// applies sign correction and the RISC-V M divide-by-zero and signed-overflow
// results, and presents the conditioned word on a registered valid/ready
// output.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. inReady is high only in IDLE, and outValid is high only in HOLD.
// Once outValid is raised, result is held stable until outReady is seen.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   inValid   in   core presents a raw result
//   inReady   out  block can accept a raw result (IDLE)
//   opCode    in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                  100 DIV 101 DIVU 110 REM 111 REMU
//   rawHi     in   product high word / remainder magnitude
//   rawLo     in   product low word / quotient magnitude
//   negQ      in   quotient must be negated
//   negR      in   remainder must be negated
//   divZero   in   divisor was zero
//   divOvf    in   signed overflow (most-negative / -1)
//   dividend  in   original dividend (REM/REMU by zero)
//   result    out  conditioned result
//   outValid  out  result is valid (HOLD)
//   outReady  in   consumer accepts the result
//   dbgState  out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module result_conditioning #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PAR-1:0]          rawHi,
  input  logic [PAR-1:0]          rawLo,
  input  logic                    negQ,
  input  logic                    negR,
  input  logic                    divZero,
  input  logic                    divOvf,
  input  logic [PAR-1:0]          dividend,
  output logic [PAR-1:0]          result,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [1:0]              dbgState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CORRECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_MUL    = OPCODE_WIDTH'(3'b000);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULH   = OPCODE_WIDTH'(3'b001);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULHSU = OPCODE_WIDTH'(3'b010);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULHU  = OPCODE_WIDTH'(3'b011);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV    = OPCODE_WIDTH'(3'b100);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIVU   = OPCODE_WIDTH'(3'b101);
  localparam logic [OPCODE_WIDTH-1:0] OP_REM    = OPCODE_WIDTH'(3'b110);
  localparam logic [OPCODE_WIDTH-1:0] OP_REMU   = OPCODE_WIDTH'(3'b111);

  localparam logic [PAR-1:0] ALL_ONES = {PAR{1'b1}};
  localparam logic [PAR-1:0] MOST_NEG = {1'b1, {(PAR-1){1'b0}}};
  localparam logic [PAR-1:0] ONE      = {{(PAR-1){1'b0}}, 1'b1};

  state_t                  r_state;
  state_t                  w_next_state;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic [PAR-1:0]          r_hi;
  logic [PAR-1:0]          r_lo;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic                    r_div_zero;
  logic                    r_div_ovf;
  logic [PAR-1:0]          r_dividend;
  logic [PAR-1:0]          r_result;
  logic [PAR-1:0]          w_value;
  logic [PAR-1:0]          w_neg_lo;
  logic [PAR-1:0]          w_neg_hi;

  // Two's complement negation; the carry out is dropped, so negating 0 gives 0.
  assign w_neg_lo = ~r_lo + ONE;
  assign w_neg_hi = ~r_hi + ONE;

  // Value selection on the captured operands. For division, divZero wins
  // over divOvf, and divOvf wins over sign correction.
  always_comb begin
    w_value = '0;
    case (r_op)
      OP_MUL:                        w_value = r_lo;
      OP_MULH, OP_MULHSU, OP_MULHU:  w_value = r_hi;
      OP_DIV: begin
        if (r_div_zero)      w_value = ALL_ONES;
        else if (r_div_ovf)  w_value = MOST_NEG;
        else if (r_neg_q)    w_value = w_neg_lo;
        else                 w_value = r_lo;
      end
      OP_DIVU:                       w_value = r_div_zero ? ALL_ONES : r_lo;
      OP_REM: begin
        if (r_div_zero)      w_value = r_dividend;
        else if (r_div_ovf)  w_value = '0;
        else if (r_neg_r)    w_value = w_neg_hi;
        else                 w_value = r_hi;
      end
      OP_REMU:                       w_value = r_div_zero ? r_dividend : r_hi;
      default:                       w_value = '0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (inValid) w_next_state = CORRECT;
      CORRECT: w_next_state = HOLD;
      HOLD:    if (outReady) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
      r_dividend <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_next_state;
      // Inputs are sampled only during the IDLE handshake, so anything the
      // core does while an operation is in flight is ignored.
      if (r_state == IDLE && inValid) begin
        r_op       <= opCode;
        r_hi       <= rawHi;
        r_lo       <= rawLo;
        r_neg_q    <= negQ;
        r_neg_r    <= negR;
        r_div_zero <= divZero;
        r_div_ovf  <= divOvf;
        r_dividend <= dividend;
      end
      if (r_state == CORRECT) begin
        r_result <= w_value;
      end
    end
  end

  assign inReady  = (r_state == IDLE);
  assign outValid = (r_state == HOLD);
  assign result   = r_result;
  assign dbgState = r_state;

endmodule

// File: tb/tb_result_conditioning.sv
module tb_result_conditioning;

  localparam int PAR = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            inValid;
  logic            inReady;
  logic [2:0]      opCode;
  logic [PAR-1:0]  rawHi;
  logic [PAR-1:0]  rawLo;
  logic            negQ;
  logic            negR;
  logic            divZero;
  logic            divOvf;
  logic [PAR-1:0]  dividend;
  logic [PAR-1:0]  result;
  logic            outValid;
  logic            outReady;
  logic [1:0]      dbgState;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PAR-1:0] exp_q[$];

  result_conditioning #(.PAR(PAR), .OPCODE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .opCode(opCode), .rawHi(rawHi), .rawLo(rawLo), .negQ(negQ), .negR(negR),
    .divZero(divZero), .divOvf(divOvf), .dividend(dividend),
    .result(result), .outValid(outValid), .outReady(outReady),
    .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Straight from the RISC-V M result rules, using plain arithmetic.
  function automatic logic [PAR-1:0] ref_model(
    input logic [2:0] op, input logic [PAR-1:0] hi, input logic [PAR-1:0] lo,
    input logic nq, input logic nr, input logic dz, input logic ov,
    input logic [PAR-1:0] dvd);
    logic [PAR-1:0] zero_w;
    zero_w = '0;
    case (op)
      3'd0: return lo;
      3'd1, 3'd2, 3'd3: return hi;
      3'd4: begin
        if (dz) return {PAR{1'b1}};
        if (ov) return 32'h8000_0000;
        if (nq) return zero_w - lo;
        return lo;
      end
      3'd5: return dz ? {PAR{1'b1}} : lo;
      3'd6: begin
        if (dz) return dvd;
        if (ov) return zero_w;
        if (nr) return zero_w - hi;
        return hi;
      end
      default: return dz ? dvd : hi;
    endcase
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [PAR-1:0] obs,
                       input logic [PAR-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    opCode   = 3'($urandom_range(0, 7));
    rawHi    = $urandom;
    rawLo    = $urandom;
    negQ     = 1'($urandom_range(0, 1));
    negR     = 1'($urandom_range(0, 1));
    divZero  = 1'($urandom_range(0, 1));
    divOvf   = 1'($urandom_range(0, 1));
    dividend = $urandom;
    inValid  = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver ----------------
  // Called one time unit after a rising edge with the DUT in IDLE. Runs one
  // full operation: the handshake, CORRECT, HOLD for `stall` cycles of
  // backpressure with scrambled inputs, and the release back to IDLE.
  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [PAR-1:0] hi, input logic [PAR-1:0] lo,
                       input logic nq, input logic nr, input logic dz,
                       input logic ov, input logic [PAR-1:0] dvd,
                       input int stall);
    logic [PAR-1:0] exp_v;
    check({tag, ".in_ready_idle"}, {31'd0, inReady}, 32'd1);
    exp_q.push_back(ref_model(op, hi, lo, nq, nr, dz, ov, dvd));
    opCode = op; rawHi = hi; rawLo = lo; negQ = nq; negR = nr;
    divZero = dz; divOvf = ov; dividend = dvd;
    inValid = 1'b1; outReady = 1'b0;
    step();                                   // cycle N+1: CORRECT
    scramble_inputs();
    outReady = 1'($urandom_range(0, 1));      // no effect outside HOLD
    check({tag, ".correct_valid"}, {31'd0, outValid}, 32'd0);
    check({tag, ".correct_ready"}, {31'd0, inReady}, 32'd0);
    step();                                   // cycle N+2: HOLD
    exp_v = exp_q.pop_front();
    inValid = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check({tag, ".hold_valid"}, {31'd0, outValid}, 32'd1);
      check({tag, ".hold_ready"}, {31'd0, inReady}, 32'd0);
      check({tag, ".hold_result"}, result, exp_v);
      scramble_inputs();
      step();
    end
    inValid = 1'b0;
    check({tag, ".out_valid"}, {31'd0, outValid}, 32'd1);
    check({tag, ".result"}, result, exp_v);
    outReady = 1'b1;
    step();                                   // back to IDLE
    outReady = 1'b0;
    check({tag, ".done_valid"}, {31'd0, outValid}, 32'd0);
    check({tag, ".done_ready"}, {31'd0, inReady}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; opCode = '0;
    rawHi = '0; rawLo = '0; negQ = 1'b0; negR = 1'b0;
    divZero = 1'b0; divOvf = 1'b0; dividend = '0;
    step(); step();
    rst = 1'b0;
    check("reset.in_ready", {31'd0, inReady}, 32'd1);
    check("reset.out_valid", {31'd0, outValid}, 32'd0);
    check("reset.result", result, 32'd0);

    // Directed cases
    do_op("mul",        3'd0, 32'hDEADBEEF, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_op("div_neg",    3'd4, 32'h1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF9, 0);
    do_op("rem_neg",    3'd6, 32'h1, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF9, 0);
    do_op("divu_noneg", 3'd5, 32'h1, 32'h3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 0);
    do_op("divu_zero",  3'd5, 32'h5, 32'h9, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 0);
    do_op("remu_zero",  3'd7, 32'h5, 32'h9, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 0);
    do_op("div_zero_ovf", 3'd4, 32'h5, 32'h9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234, 0);
    do_op("rem_zero_ovf", 3'd6, 32'h5, 32'h9, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234, 0);
    do_op("div_ovf",    3'd4, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 0);
    do_op("rem_ovf",    3'd6, 32'h0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 0);
    do_op("div_neg0",   3'd4, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 0);
    do_op("rem_neg0",   3'd6, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 0);
    do_op("mulhu",      3'd3, 32'hCAFE_F00D, 32'h1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2, 0);
    do_op("backpressure", 3'd2, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5);
    do_op("mulh_after", 3'd1, 32'h7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Reset during CORRECT drops the operation
    opCode = 3'd0; rawLo = 32'hA5A5_A5A5; inValid = 1'b1;
    step();
    inValid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid.out_valid", {31'd0, outValid}, 32'd0);
    check("rst_mid.in_ready", {31'd0, inReady}, 32'd1);
    check("rst_mid.result", result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid.no_result", {31'd0, outValid}, 32'd0);
    end

    // Randomised operations with random backpressure
    for (int k = 0; k < 60; k++) begin
      logic [2:0]     r_op;
      logic [PAR-1:0] r_hi;
      logic [PAR-1:0] r_lo;
      r_op = 3'($urandom_range(0, 7));
      r_hi = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      r_lo = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      do_op("rand", r_op, r_hi, r_lo,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_conditioning.md
Name: result_conditioning

Overview:
- Output-side counterpart of operand conditioning in the multiply/divide unit.
- Takes raw unsigned-magnitude results from the multiply/divide core (product high/low words, or quotient/remainder magnitudes plus sign-fix flags).
- Selects the word the opCode requires and applies sign correction and RISC-V M special cases (divide-by-zero, signed overflow).
- Delivers one PAR-bit result through a registered valid/ready output.

Parameters:
PAR, 32, datapath word width in bits
OPCODE_WIDTH, 3, opCode width

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
inValid  input  1  core presents a raw result
inReady  output  1  block can accept a raw result
opCode  input  OPCODE_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rawHi  input  PAR  product high word, or remainder magnitude
rawLo  input  PAR  product low word, or quotient magnitude
negQ  input  1  quotient must be negated (signed division only)
negR  input  1  remainder must be negated (signed division only)
divZero  input  1  divisor was zero
divOvf  input  1  signed overflow (most-negative / -1)
dividend  input  PAR  original dividend, used for REM/REMU by zero
result  output  PAR  conditioned result
outValid  output  1  result is valid
outReady  input  1  consumer accepts the result

Behaviour:
Reset (synchronous, active-high):
- state=IDLE, inReady=1, outValid=0, result=0, internal registers cleared.
- Reset asserted in any state, including mid-operation, drops the operation in the next cycle.
- No partial result is emitted.

FSM states: IDLE, CORRECT, HOLD.
- IDLE: inReady=1, outValid=0. When inValid=1, capture opCode, rawHi, rawLo, negQ, negR, divZero, divOvf, dividend, then go to CORRECT.
- CORRECT: inReady=0, outValid=0. Compute the value below, register it into result, go to HOLD.
- HOLD: inReady=0, outValid=1, result stable. On outReady=1 go to IDLE. Otherwise stay in HOLD with result held unchanged for any number of cycles.

Latency and throughput:
- Input handshake in cycle N gives outValid=1 from cycle N+2.
- Minimum 3 cycles per operation. The next input is accepted in the cycle after the output handshake.

Value selection (on captured values):
- MUL: rawLo.
- MULH, MULHSU, MULHU: rawHi. The core already produced a signed product.
- DIV:
  - if divZero: all ones;
  - else if divOvf: 1 followed by PAR-1 zeros;
  - else if negQ: two's complement of rawLo (~rawLo+1, truncated to PAR);
  - else rawLo.
- DIVU: all ones if divZero, else rawLo. negQ and divOvf are ignored.
- REM:
  - if divZero: dividend;
  - else if divOvf: 0;
  - else if negR: ~rawHi+1;
  - else rawHi.
- REMU: dividend if divZero, else rawHi.

Priority and edge rules:
- For division, divZero takes priority over divOvf, which takes priority over negation.
- Negating 0 yields 0.
- Input signals are ignored outside the IDLE handshake. Changes while in CORRECT or HOLD have no effect.
- outReady outside HOLD has no effect.

Test Plan:
- MUL, PAR=32, rawLo=0x00000006, rawHi=0xDEADBEEF, outReady=1 -> result=0x00000006, outValid for exactly 1 cycle at N+2; inReady returns to 1 at N+3.
- DIV -7/2: rawLo=3, negQ=1 -> 0xFFFFFFFD. REM with rawHi=1, negR=1 -> 0xFFFFFFFF. DIVU with rawLo=3, negQ=1 -> 0x00000003.
- Divide by zero, dividend=0x00001234, divZero=1:
  - DIVU -> 0xFFFFFFFF; REMU -> 0x00001234;
  - DIV with divOvf=1 also set -> 0xFFFFFFFF (divZero wins).
- Overflow, divOvf=1: DIV -> 0x80000000; REM -> 0x00000000.
- Backpressure: outReady low for 5 cycles in HOLD, inputs toggled meanwhile:
  - result, outValid=1 and inReady=0 stay stable;
  - outReady high -> IDLE next cycle, and a new MULH (rawHi=0x7) is accepted and returns 0x00000007.
- Reset mid-op: rst=1 during CORRECT -> next cycle outValid=0, inReady=1, result=0. The aborted result never appears.
